jtkicker_sdram_arb: RTL and testbench
=====================================

JTKICKER_SDRAM_ARB -- requirements
Module: jtkicker_sdram_arb

Interface
REQ-001 The module SHALL have the parameter AW, default 22, meaning the SDRAM word-address width.
REQ-002 The module SHALL have the port rst  input  1  asynchronous active-high reset.
REQ-003 The module SHALL have the port clk  input  1  system clock; the module SHALL use this as its only clock.
REQ-004 The module SHALL have the port downloading  input  1  ROM download in progress.
REQ-005 The module SHALL have the ports slotN_cs  input  1  request enable, for N=0..3.
REQ-006 The module SHALL have the ports slotN_addr  input  AW  word address, for N=0..3.
REQ-007 The module SHALL have the ports slotN_ok  output  1  data valid for the current address, for N=0..3.
REQ-008 The module SHALL have the ports slotN_dout  output  16  cached word, for N=0..3.
REQ-009 The module SHALL have the port sdram_req  output  1  access request.
REQ-010 The module SHALL have the port sdram_addr  output  AW  word address of the access.
REQ-011 The module SHALL have the port sdram_ack  input  1  request accepted, one-cycle pulse.
REQ-012 The module SHALL have the port data_rdy  input  1  data_read valid, one-cycle pulse.
REQ-013 The module SHALL have the port data_read  input  16  SDRAM read data.

Function
REQ-014 Each slot SHALL hold a one-word cache: a valid bit, a tag (AW bits) and data (16 bits).
REQ-015 slotN_ok SHALL be combinational and equal slotN_cs AND validN AND (tagN == slotN_addr).
REQ-016 slotN_dout SHALL always present dataN, regardless of ok.
REQ-017 A slot SHALL be missing when slotN_cs=1 and slotN_ok=0.
REQ-018 The FSM SHALL have three states: IDLE, REQ and WAIT.
REQ-019 In IDLE with no missing slot, the FSM SHALL stay in IDLE.
REQ-020 In IDLE with one or more missing slots, the FSM SHALL grant by fixed priority, slot3 highest and slot0 lowest.
REQ-021 On a grant, the FSM SHALL register the grant index and sdram_addr (latched from the granted slot's address), set sdram_req=1 and go to REQ on the next edge.
REQ-022 In REQ, sdram_req SHALL hold at 1 and sdram_addr SHALL stay stable until sdram_ack=1.
REQ-023 On sdram_ack=1 in REQ, sdram_req SHALL fall to 0 and the FSM SHALL go to WAIT.
REQ-024 In WAIT, on data_rdy=1, the FSM SHALL write the granted slot's data from data_read and its tag from the latched sdram_addr, set its valid to 1, and return to IDLE, all on the same edge.
REQ-025 The latency from a miss visible at edge k SHALL be: sdram_req high after edge k; slot ok high the cycle after the data_rdy edge, provided the address is unchanged.
REQ-026 A new grant SHALL be possible on the edge following the return to IDLE, giving back-to-back service.
REQ-027 If a slot's address changes while it is in flight, the fill SHALL complete with the old tag, ok SHALL stay 0, and the slot SHALL re-request from IDLE.
REQ-028 If slotN_cs drops while the slot is in flight, the transfer SHALL complete and the cache SHALL be filled; ok SHALL stay 0 because cs=0.
REQ-029 Arbitration SHALL happen only in IDLE: a higher-priority miss SHALL NOT preempt an access in REQ or WAIT.
REQ-030 data_rdy in IDLE or REQ, and sdram_ack outside REQ, SHALL be ignored.
REQ-031 While downloading=1, the FSM SHALL be forced to IDLE, sdram_req SHALL be 0, all valid bits SHALL be cleared every cycle, and no grant SHALL be made.
REQ-032 Arbitration SHALL resume on the first edge after downloading falls.

Reset
REQ-033 On rst=1, asynchronously: state=IDLE, sdram_req=0, sdram_addr=0, grant index=0, all valid=0, all tags=0 and all data=0.
REQ-034 Consequently, all slotN_ok SHALL be 0 and all slotN_dout SHALL be 0 during reset.
REQ-035 A reset asserted during REQ or WAIT SHALL abort the access; a late data_rdy after reset release SHALL be ignored per REQ-030.

Verification
REQ-036 The bench SHALL cover a single miss: slot1 cs=1, addr=0x00123; ack 2 cycles after req; data_rdy 5 cycles later with data 0xBEEF -> sdram_addr=0x00123, slot1_ok=1, slot1_dout=0xBEEF the cycle after data_rdy.
REQ-037 The bench SHALL cover a priority collision: slot0 and slot3 miss on the same cycle -> slot3 is serviced first, slot0 is granted on the edge after slot3's fill.
REQ-038 The bench SHALL cover an address change in flight: slot2 addr changes from 0x10 to 0x11 while in WAIT -> slot2_ok stays 0, and a second request with sdram_addr=0x11 follows.
REQ-039 The bench SHALL cover a hit: re-present a filled address -> ok=1 combinationally and no sdram_req.
REQ-040 The bench SHALL cover a download: assert downloading during WAIT -> sdram_req=0, all ok=0; after release a pending miss is requested again.
REQ-041 The bench SHALL cover reset mid-access: rst pulse in REQ -> sdram_req=0 immediately; a subsequent stray data_rdy leaves all ok=0.

Source files
------------

// File: rtl/jtkicker_sdram_arb.sv
// Four-slot SDRAM read arbiter; each slot caches one 16-bit word behind a tag.
// Latency: request rises one edge after a miss; slot ok rises the cycle after the data_rdy edge.
// Backpressure: sdram_req/sdram_addr hold until sdram_ack; slots wait on ok, one access in flight.
// Ports: slotN_cs/slotN_addr request a word; slotN_ok/slotN_dout return the cached word;
//        sdram_req/sdram_addr/sdram_ack form the request handshake; data_rdy/data_read return data;
//        downloading invalidates every slot and blocks new accesses.
module jtkicker_sdram_arb #(
  parameter int AW = 22
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          downloading,
  input  logic          slot0_cs,
  input  logic          slot1_cs,
  input  logic          slot2_cs,
  input  logic          slot3_cs,
  input  logic [AW-1:0] slot0_addr,
  input  logic [AW-1:0] slot1_addr,
  input  logic [AW-1:0] slot2_addr,
  input  logic [AW-1:0] slot3_addr,
  output logic          slot0_ok,
  output logic          slot1_ok,
  output logic          slot2_ok,
  output logic          slot3_ok,
  output logic [15:0]   slot0_dout,
  output logic [15:0]   slot1_dout,
  output logic [15:0]   slot2_dout,
  output logic [15:0]   slot3_dout,
  output logic          sdram_req,
  output logic [AW-1:0] sdram_addr,
  input  logic          sdram_ack,
  input  logic          data_rdy,
  input  logic [15:0]   data_read
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

  state_t        state_q, state_d;
  logic          req_q, req_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          fill;

  logic [3:0]    valid_q;
  logic [AW-1:0] tag_q  [4];
  logic [15:0]   data_q [4];

  logic [3:0]    cs;
  logic [AW-1:0] addr [4];
  logic [3:0]    ok;
  logic [3:0]    miss;

  assign cs      = {slot3_cs, slot2_cs, slot1_cs, slot0_cs};
  assign addr[0] = slot0_addr;
  assign addr[1] = slot1_addr;
  assign addr[2] = slot2_addr;
  assign addr[3] = slot3_addr;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ok[i] = cs[i] & valid_q[i] & (tag_q[i] == addr[i]);
    end
  end

  assign miss = cs & ~ok;

  assign slot0_ok   = ok[0];
  assign slot1_ok   = ok[1];
  assign slot2_ok   = ok[2];
  assign slot3_ok   = ok[3];
  assign slot0_dout = data_q[0];
  assign slot1_dout = data_q[1];
  assign slot2_dout = data_q[2];
  assign slot3_dout = data_q[3];
  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    gnt_d   = gnt_q;
    fill    = 1'b0;
    if (downloading) begin
      // Download rewrites the ROM: drop any access in progress, nothing is granted.
      state_d = ST_IDLE;
      req_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|miss) begin
            if (miss[3])      gnt_d = 2'd3;
            else if (miss[2]) gnt_d = 2'd2;
            else if (miss[1]) gnt_d = 2'd1;
            else              gnt_d = 2'd0;
            addr_d  = addr[gnt_d];
            req_d   = 1'b1;
            state_d = ST_REQ;
          end
        end
        ST_REQ: begin
          if (sdram_ack) begin
            req_d   = 1'b0;
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (data_rdy) begin
            // Tag comes from the latched address, so a slot that moved on stays a miss.
            fill    = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      gnt_q   <= 2'd0;
      valid_q <= 4'b0;
      for (int i = 0; i < 4; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= 16'h0;
      end
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      gnt_q   <= gnt_d;
      for (int i = 0; i < 4; i++) begin
        if (downloading) begin
          valid_q[i] <= 1'b0;
        end else if (fill && (gnt_q == 2'(i))) begin
          valid_q[i] <= 1'b1;
          tag_q[i]   <= addr_q;
          data_q[i]  <= data_read;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtkicker_sdram_arb.sv
// Bench for the four-slot SDRAM arbiter: acts as the SDRAM, keeps a per-slot cache model
// and predicts the granted slot from the priority rule; directed scenarios then random traffic.
module tb_jtkicker_sdram_arb;
  localparam int AW = 22;

  logic          rst, clk, downloading;
  logic          cs_t   [4];
  logic [AW-1:0] addr_t [4];
  logic          ok_w   [4];
  logic [15:0]   dout_w [4];
  logic          sdram_req, sdram_ack, data_rdy;
  logic [AW-1:0] sdram_addr;
  logic [15:0]   data_read;

  int checks = 0;
  int errors = 0;

  // Reference cache contents
  bit            mv [4];
  logic [AW-1:0] mt [4];
  logic [15:0]   md [4];

  jtkicker_sdram_arb #(.AW(AW)) dut (
    .rst(rst), .clk(clk), .downloading(downloading),
    .slot0_cs(cs_t[0]), .slot1_cs(cs_t[1]), .slot2_cs(cs_t[2]), .slot3_cs(cs_t[3]),
    .slot0_addr(addr_t[0]), .slot1_addr(addr_t[1]), .slot2_addr(addr_t[2]), .slot3_addr(addr_t[3]),
    .slot0_ok(ok_w[0]), .slot1_ok(ok_w[1]), .slot2_ok(ok_w[2]), .slot3_ok(ok_w[3]),
    .slot0_dout(dout_w[0]), .slot1_dout(dout_w[1]), .slot2_dout(dout_w[2]), .slot3_dout(dout_w[3]),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .data_rdy(data_rdy), .data_read(data_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit mdl_hit(input int i);
    return cs_t[i] && mv[i] && (mt[i] == addr_t[i]);
  endfunction

  // Highest-numbered requesting slot whose cached word does not match; -1 if none.
  function automatic int mdl_grant();
    for (int i = 3; i >= 0; i--) begin
      if (cs_t[i] && !mdl_hit(i)) return i;
    end
    return -1;
  endfunction

  task automatic mdl_clear_all();
    for (int i = 0; i < 4; i++) begin
      mv[i] = 1'b0; mt[i] = '0; md[i] = 16'h0;
    end
  endtask

  task automatic check_slots(input string tag);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_ok%0d", tag, i), 32'(ok_w[i]), 32'(mdl_hit(i)));
      check($sformatf("%s_dout%0d", tag, i), 32'(dout_w[i]), 32'(md[i]));
    end
  endtask

  task automatic wait_req(output int wc);
    wc = 0;
    while (sdram_req !== 1'b1 && wc < 20) begin
      @(negedge clk);
      wc++;
    end
    check("req_seen", 32'(sdram_req), 32'd1);
  endtask

  // Serve one access as the SDRAM. Optionally move a slot's address once the access is acked.
  task automatic service(input logic [15:0] d, input int ack_dly, input int rdy_dly,
                         input int chg_slot, input logic [AW-1:0] chg_addr,
                         output int wc, output logic [AW-1:0] got_addr);
    int g;
    logic [AW-1:0] a;
    g = mdl_grant();
    got_addr = '0;
    check("grant_pending", 32'(g >= 0), 32'd1);
    wait_req(wc);
    if (g < 0 || sdram_req !== 1'b1) return;
    a = addr_t[g];
    got_addr = sdram_addr;
    check("sdram_addr", 32'(sdram_addr), 32'(a));
    repeat (ack_dly) begin
      @(negedge clk);
      check("req_hold", 32'(sdram_req), 32'd1);
      check("addr_hold", 32'(sdram_addr), 32'(a));
    end
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    check("req_fall", 32'(sdram_req), 32'd0);
    if (chg_slot >= 0) addr_t[chg_slot] = chg_addr;
    repeat (rdy_dly) @(negedge clk);
    #1 check_slots("wait");
    data_read = d;
    data_rdy  = 1'b1;
    @(negedge clk);
    data_rdy  = 1'b0;
    mv[g] = 1'b1; mt[g] = a; md[g] = d;
    check_slots("fill");
  endtask

  task automatic drain();
    int n, wc;
    logic [AW-1:0] ga;
    n = 0;
    while (mdl_grant() >= 0 && n < 8) begin
      service(16'($urandom), $urandom_range(0, 3), $urandom_range(0, 4), -1, '0, wc, ga);
      n++;
    end
  endtask

  initial begin
    int wc;
    logic [AW-1:0] ga;
    rst = 1'b1; downloading = 1'b0; sdram_ack = 1'b0; data_rdy = 1'b0; data_read = 16'h0;
    for (int i = 0; i < 4; i++) begin cs_t[i] = 1'b1; addr_t[i] = '0; end
    mdl_clear_all();

    // Reset state
    #12;
    check("rst_req", 32'(sdram_req), 32'd0);
    check("rst_addr", 32'(sdram_addr), 32'd0);
    check_slots("rst");
    @(negedge clk);
    for (int i = 0; i < 4; i++) cs_t[i] = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_req", 32'(sdram_req), 32'd0);

    // Single miss on slot1
    cs_t[1] = 1'b1; addr_t[1] = 22'h00123;
    service(16'hBEEF, 2, 5, -1, '0, wc, ga);
    check("single_latency", 32'(wc), 32'd1);
    check("single_addr", 32'(ga), 32'h00123);
    check("single_ok", 32'(ok_w[1]), 32'd1);
    check("single_dout", 32'(dout_w[1]), 32'hBEEF);

    // Hit: drop and re-present the filled address
    cs_t[1] = 1'b0;
    #1 check("hit_cs0_ok", 32'(ok_w[1]), 32'd0);
    check("hit_dout_kept", 32'(dout_w[1]), 32'hBEEF);
    @(negedge clk);
    cs_t[1] = 1'b1;
    #1 check("hit_ok", 32'(ok_w[1]), 32'd1);
    repeat (2) begin
      @(negedge clk);
      check("hit_no_req", 32'(sdram_req), 32'd0);
    end

    // Priority collision: slot0 and slot3 miss together
    cs_t[0] = 1'b1; addr_t[0] = 22'h00040;
    cs_t[3] = 1'b1; addr_t[3] = 22'h00300;
    service(16'h3333, 1, 2, -1, '0, wc, ga);
    check("prio_first", 32'(ga), 32'h00300);
    check("prio_s0_pending", 32'(ok_w[0]), 32'd0);
    service(16'h0000, 0, 1, -1, '0, wc, ga);
    check("prio_second", 32'(ga), 32'h00040);
    check("prio_b2b", 32'(wc), 32'd1);
    check("prio_s0_ok", 32'(ok_w[0]), 32'd1);

    // Address change while slot2 is in flight
    cs_t[2] = 1'b1; addr_t[2] = 22'h00010;
    service(16'h1010, 1, 3, 2, 22'h00011, wc, ga);
    check("chg_first", 32'(ga), 32'h00010);
    check("chg_ok_low", 32'(ok_w[2]), 32'd0);
    service(16'h1111, 1, 1, -1, '0, wc, ga);
    check("chg_rereq", 32'(ga), 32'h00011);
    check("chg_rereq_lat", 32'(wc), 32'd1);
    check("chg_ok", 32'(ok_w[2]), 32'd1);

    // Download during WAIT
    addr_t[0] = 22'h00200;
    wait_req(wc);
    check("dl_addr", 32'(sdram_addr), 32'h00200);
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    downloading = 1'b1;
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) mv[i] = 1'b0;
      check("dl_req", 32'(sdram_req), 32'd0);
      check_slots("dl");
    end
    downloading = 1'b0;
    service(16'hD003, 1, 1, -1, '0, wc, ga);
    check("dl_resume_lat", 32'(wc), 32'd1);
    check("dl_resume_addr", 32'(ga), 32'h00300);
    drain();
    check("dl_s0_refilled", 32'(ok_w[0]), 32'd1);

    // Reset pulse while in REQ, then a stray data_rdy
    addr_t[1] = 22'h00055;
    wait_req(wc);
    check("rr_addr", 32'(sdram_addr), 32'h00055);
    #2 rst = 1'b1;
    mdl_clear_all();
    #1;
    check("rr_req", 32'(sdram_req), 32'd0);
    check("rr_addr0", 32'(sdram_addr), 32'd0);
    check_slots("rr");
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin cs_t[i] = 1'b0; addr_t[i] = '0; end
    rst = 1'b0;
    @(negedge clk);
    data_read = 16'h1234; data_rdy = 1'b1;
    @(negedge clk);
    data_rdy = 1'b0;
    for (int i = 0; i < 4; i++) cs_t[i] = 1'b1;
    #1 check_slots("stray");
    drain();
    for (int i = 0; i < 4; i++) cs_t[i] = 1'b0;

    // Random traffic
    for (int it = 0; it < 30; it++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        cs_t[i] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 2) == 0) addr_t[i] = AW'(22'h00100 + $urandom_range(0, 3));
      end
      #1 check_slots("rnd");
      drain();
      @(negedge clk);
      check("rnd_quiet", 32'(sdram_req), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
